program_sequencer: RTL
======================

Name: program_sequencer

Overview:
- Parametrised successor to the systolic-array program counter.
- Holds a host-writable instruction memory and fetches instructions in order from a start address.
- Issues each array instruction to the array with a one-cycle init_inst_pulse, then waits for the array's completion flag.
- Executes its own control opcodes internally and never issues them: halt, jump, and (optionally) a counted hardware loop.

Parameters:
PC_DEPTH, 1024, instruction memory depth in words (power of two); PC_ADDR_BITS = $clog2(PC_DEPTH)
INST_BITS, 128, instruction word width
OPCODE_BITS, 8, opcode field width; opcode = instruction[INST_BITS-1 -: OPCODE_BITS]
LOOP_CNT_BITS, 16, loop repeat-count width
INIT_FILE, "", hex file loaded into memory at elaboration; empty = no load
OP_HALT, 8'hF0, sequencer halt opcode
OP_JUMP, 8'hF1, sequencer jump opcode; target = instruction[PC_ADDR_BITS-1:0]
OP_LOOP, 8'hF2, sequencer loop opcode; target = instruction[PC_ADDR_BITS-1:0], count = instruction[PC_ADDR_BITS +: LOOP_CNT_BITS]

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock, reset is synchronous and active-low
start  in  1  begin execution at start_addr; accepted only in IDLE or HALT
start_addr  in  PC_ADDR_BITS  first instruction address
flag  in  1  array completion pulse for the issued instruction
force_inst  in  1  re-issue the current instruction while waiting
wr_en  in  1  host instruction-memory write strobe
wr_addr  in  PC_ADDR_BITS  write address
wr_data  in  INST_BITS  write data
instruction  out  INST_BITS  last issued instruction, held stable until the next issue
init_inst_pulse  out  1  one-cycle strobe marking a new or re-issued instruction
pc  out  PC_ADDR_BITS  current program counter
busy  out  1  high in FETCH, DECODE or WAIT
halted  out  1  high in HALT
error  out  1  sticky error flag; cleared by reset or an accepted start

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE; instruction=0, init_inst_pulse=0, pc=0, busy=0, halted=0, error=0, loop state cleared. Memory contents are preserved. Reset applies immediately, including mid-WAIT.
- Memory: single-port synchronous read, 1-cycle read latency.
- Host writes are accepted only in IDLE or HALT. A wr_en in any other state is dropped and sets error.
- States: IDLE, FETCH, DECODE, WAIT, HALT.
- IDLE/HALT + start: pc<=start_addr, error<=0, halted<=0, go to FETCH. start in any other state is ignored.
- FETCH: read mem[pc], go to DECODE.
- DECODE, OP_HALT: go to HALT; pc holds the halt address.
- DECODE, OP_JUMP: pc<=target, go to FETCH.
- DECODE, OP_LOOP: see Optional Feature.
- DECODE, any other opcode: instruction<=word, init_inst_pulse<=1 for exactly one cycle, go to WAIT.
- Latency: from start or flag sampled at edge E to init_inst_pulse registered at edge E+2. Each control opcode costs 2 cycles.
- WAIT + flag: if pc==PC_DEPTH-1, set error and go to HALT (no wrap). Otherwise pc<=pc+1 and go to FETCH.
- WAIT + force_inst (without flag): init_inst_pulse<=1 for one cycle; instruction and pc unchanged.
- flag and force_inst in the same cycle: flag wins, no re-issue.
- flag outside WAIT: ignored.
- A jump to its own address loops forever by design; only reset or the host can break it.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined: the sequencer keeps loop_active and a loop_cnt register. DECODE OP_LOOP behaves as follows:
  - Inactive, count==0: pc+1.
  - Inactive, count>0: loop_cnt<=count-1, loop_active<=1, pc<=target.
  - Active, loop_cnt>0: loop_cnt-1, pc<=target.
  - Active, loop_cnt==0: loop_active<=0, pc+1.
  - Net effect: the body between target and the loop opcode runs count+1 times. Nested loops are unsupported; the inner loop shares the register.
- Undefined: OP_LOOP is illegal; it sets error and goes to HALT without issuing. No loop registers are synthesised.

Test Plan:
- Write mem[0]=0x01..,mem[1]=0x02..,mem[2]=OP_HALT; start, start_addr=0; return flag 3 cycles after each pulse -> exactly 2 pulses, instruction opcodes 0x01 then 0x02, halted=1, pc=2, error=0.
- Start sampled at edge 10 -> init_inst_pulse high after edge 12 only; flag at edge 20 -> next pulse after edge 22.
- mem[4]=OP_JUMP target 8, mem[8]=0x05, mem[9]=OP_HALT; start at 4 -> single issue of 0x05; mem[5..7] are never issued.
- (SEQ_LOOP_EN) mem[0]=0x07, mem[1]=OP_LOOP count=2 target=0, mem[2]=OP_HALT -> 0x07 issued 3 times, then halted. Without the macro -> 1 issue, then error=1, halted=1.
- In WAIT: force_inst pulse -> extra init_inst_pulse with the same instruction. flag+force_inst together -> no re-issue, pc advances. wr_en in WAIT -> error=1, memory unchanged.
- Assert reset_n=0 in WAIT -> all outputs 0 next cycle, state IDLE. Restart at 0 -> original program executes correctly (memory retained).

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer: fetches instructions from a host-writable memory and issues them to the array.
module program_sequencer #(
  parameter int PC_DEPTH = 1024,
  parameter int INST_BITS = 128,
  parameter int OPCODE_BITS = 8,
  parameter int LOOP_CNT_BITS = 16,
  parameter string INIT_FILE = "",
  parameter logic [OPCODE_BITS-1:0] OP_HALT = 8'hF0,
  parameter logic [OPCODE_BITS-1:0] OP_JUMP = 8'hF1,
  parameter logic [OPCODE_BITS-1:0] OP_LOOP = 8'hF2,
  localparam int PC_ADDR_BITS = $clog2(PC_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [PC_ADDR_BITS-1:0] start_addr,
  input  logic                    flag,
  input  logic                    force_inst,
  input  logic                    wr_en,
  input  logic [PC_ADDR_BITS-1:0] wr_addr,
  input  logic [INST_BITS-1:0]    wr_data,
  output logic [INST_BITS-1:0]    instruction,
  output logic                    init_inst_pulse,
  output logic [PC_ADDR_BITS-1:0] pc,
  output logic                    busy,
  output logic                    halted,
  output logic                    error
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT, HALT} state_t;
  state_t state;
  logic [INST_BITS-1:0] mem [PC_DEPTH];
  logic [INST_BITS-1:0] word;
  logic [OPCODE_BITS-1:0] opcode;
  logic [PC_ADDR_BITS-1:0] target;
  logic host_ok;
  assign opcode = word[INST_BITS-1 -: OPCODE_BITS];
  assign target = word[PC_ADDR_BITS-1:0];
  assign host_ok = (state == IDLE) || (state == HALT);
`ifdef SEQ_LOOP_EN
  logic loop_active;
  logic [LOOP_CNT_BITS-1:0] loop_cnt;
  logic [LOOP_CNT_BITS-1:0] count;
  assign count = word[PC_ADDR_BITS +: LOOP_CNT_BITS];
`endif
  always_ff @(posedge clk) begin
    if (wr_en && host_ok) mem[wr_addr] <= wr_data;
    if (state == FETCH) word <= mem[pc];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      instruction <= '0;
      init_inst_pulse <= 1'b0;
      pc <= '0;
      busy <= 1'b0;
      halted <= 1'b0;
      error <= 1'b0;
`ifdef SEQ_LOOP_EN
      loop_active <= 1'b0;
      loop_cnt <= '0;
`endif
    end else begin
      init_inst_pulse <= 1'b0;
      if (wr_en && !host_ok) error <= 1'b1;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc <= start_addr;
            error <= 1'b0;
            halted <= 1'b0;
            busy <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (opcode == OP_HALT) begin
            busy <= 1'b0;
            halted <= 1'b1;
            state <= HALT;
          end else if (opcode == OP_JUMP) begin
            pc <= target;
            state <= FETCH;
          end else if (opcode == OP_LOOP) begin
`ifdef SEQ_LOOP_EN
            state <= FETCH;
            if (loop_active) begin
              if (loop_cnt != '0) begin
                loop_cnt <= loop_cnt - 1'b1;
                pc <= target;
              end else begin
                loop_active <= 1'b0;
                pc <= pc + 1'b1;
              end
            end else if (count != '0) begin
              loop_cnt <= count - 1'b1;
              loop_active <= 1'b1;
              pc <= target;
            end else begin
              pc <= pc + 1'b1;
            end
`else
            error <= 1'b1;
            busy <= 1'b0;
            halted <= 1'b1;
            state <= HALT;
`endif
          end else begin
            instruction <= word;
            init_inst_pulse <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flag) begin
            if (pc == PC_ADDR_BITS'(PC_DEPTH - 1)) begin
              error <= 1'b1;
              busy <= 1'b0;
              halted <= 1'b1;
              state <= HALT;
            end else begin
              pc <= pc + 1'b1;
              state <= FETCH;
            end
          end else if (force_inst) begin
            init_inst_pulse <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
